// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the pipeline hazard unit
package pipe_pkg;

    localparam logic [2:0] FWD_RF   = 3'b000;
    localparam logic [2:0] FWD_EXA  = 3'b001;
    localparam logic [2:0] FWD_MEMA = 3'b010;
    localparam logic [2:0] FWD_MEML = 3'b011;
    localparam logic [2:0] FWD_MC   = 3'b100;

    // Width of the multi-cycle countdown; covers MC_LAT up to 255
    localparam int MC_CNT_W = 8;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hz_src_match.sv
// rtl/hz_src_match.sv - per-source match and forward select for one ID operand
module hz_src_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_use,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [REG_AW-1:0] ern,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [REG_AW-1:0] mrn,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_rd,
    output logic [2:0]        fwd,
    output logic              ld_hit,
    output logic              mc_hit
);

    logic ex_match;
    logic mem_match;
    logic mc_fwd;

    // Stage matches ignore $0 and sources the instruction does not actually read
    always_comb begin
        ex_match  = src_use & ewreg & (ern != '0) & (ern == src);
        mem_match = src_use & mwreg & (mrn != '0) & (mrn == src);
        mc_fwd    = mc_done & (mc_rd != '0) & (mc_rd == src);
        ld_hit    = ex_match & em2reg;
        mc_hit    = src_use & (mc_rd != '0) & (mc_rd == src);
    end

    // Forward select: the completing mc result is youngest, then EX, then MEM
    always_comb begin
        fwd = FWD_RF;
        if (mc_fwd) begin
            fwd = FWD_MC;
        end else if (ex_match) begin
            fwd = FWD_EXA;
        end else if (mem_match) begin
            fwd = mm2reg ? FWD_MEML : FWD_MEMA;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/forward/flush control with multi-cycle unit tracking
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NSRC*REG_AW-1:0]   id_src,
    input  logic [NSRC-1:0]          id_use,
    input  logic                     id_wreg,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_mc,
    input  logic                     id_br_taken,
    input  logic                     ewreg,
    input  logic                     em2reg,
    input  logic [REG_AW-1:0]        ern,
    input  logic                     mwreg,
    input  logic                     mm2reg,
    input  logic [REG_AW-1:0]        mrn,
    output logic [NSRC*3-1:0]        fwd,
    output logic                     wpcir,
    output logic                     bubble,
    output logic                     flush_if,
    output logic                     mc_busy,
    output logic                     mc_done,
    output logic [REG_AW-1:0]        mc_rd,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 1);

    mc_state_t             state, state_n;
    logic [MC_CNT_W-1:0]   cnt, cnt_n;
    logic [REG_AW-1:0]     rd_n;
    logic                  done_n;
    logic [NSRC-1:0]       ld_hit;
    logic [NSRC-1:0]       mc_hit;
    logic                  mc_block;
    logic                  any_stall;
    logic                  issue;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            hz_src_match #(.REG_AW(REG_AW)) u_match (
                .src     (id_src[gi*REG_AW +: REG_AW]),
                .src_use (id_use[gi]),
                .ewreg   (ewreg),
                .em2reg  (em2reg),
                .ern     (ern),
                .mwreg   (mwreg),
                .mm2reg  (mm2reg),
                .mrn     (mrn),
                .mc_done (mc_done),
                .mc_rd   (mc_rd),
                .fwd     (fwd[gi*3 +: 3]),
                .ld_hit  (ld_hit[gi]),
                .mc_hit  (mc_hit[gi])
            );
        end
    endgenerate

    // Stall sources; the mc unit stops blocking in its done cycle so a dependant can proceed via forwarding
    always_comb begin
        mc_block  = mc_busy & ~mc_done;
        any_stall = (|ld_hit)
                  | (mc_block & (|mc_hit))
                  | (mc_block & id_wreg & (id_rd == mc_rd))
                  | (mc_block & id_mc);
        wpcir     = ~any_stall;
        bubble    = any_stall;
        flush_if  = id_br_taken & ~any_stall;
        issue     = id_mc & ~any_stall;
        mc_busy   = (state == MC_BUSY);
    end

    // Multi-cycle unit next state: load countdown on issue, reload back-to-back in the done cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = mc_rd;
        case (state)
            MC_IDLE: begin
                if (issue) begin
                    state_n = MC_BUSY;
                    cnt_n   = MC_LOAD;
                    rd_n    = id_wreg ? id_rd : '0;
                end
            end
            MC_BUSY: begin
                if (cnt == '0) begin
                    if (issue) begin
                        cnt_n = MC_LOAD;
                        rd_n  = id_wreg ? id_rd : '0;
                    end else begin
                        state_n = MC_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = MC_IDLE;
        endcase
        done_n = (state_n == MC_BUSY) && (cnt_n == '0);
    end

    // Multi-cycle unit registers; reset abandons any op in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= MC_IDLE;
            cnt     <= '0;
            mc_rd   <= '0;
            mc_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mc_rd   <= rd_n;
            mc_done <= done_n;
        end
    end

    // Saturating count of cycles in which the front end was held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (any_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

    localparam int REG_AW = 5;
    localparam int NSRC   = 2;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        id_use;
    logic                   id_wreg;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_mc;
    logic                   id_br_taken;
    logic                   ewreg, em2reg;
    logic [REG_AW-1:0]      ern;
    logic                   mwreg, mm2reg;
    logic [REG_AW-1:0]      mrn;
    logic [NSRC*3-1:0]      fwd;
    logic                   wpcir, bubble, flush_if, mc_busy, mc_done;
    logic [REG_AW-1:0]      mc_rd;
    logic [CNT_W-1:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    // model state: cycles of mc occupancy left, its destination, stall count
    int                m_left = 0;
    logic [REG_AW-1:0] m_rd = '0;
    int                m_cnt = 0;
    logic              exp_wpcir = 1'b1;

    pipe_hazard_unit #(.REG_AW(REG_AW), .NSRC(NSRC), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .id_src(id_src), .id_use(id_use), .id_wreg(id_wreg),
        .id_rd(id_rd), .id_mc(id_mc), .id_br_taken(id_br_taken), .ewreg(ewreg), .em2reg(em2reg),
        .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwd(fwd), .wpcir(wpcir),
        .bubble(bubble), .flush_if(flush_if), .mc_busy(mc_busy), .mc_done(mc_done),
        .mc_rd(mc_rd), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare: derive every output from the hazard rules at mid-cycle
    always @(negedge clock) begin
        logic              busy_m, done_m, blk, stall;
        logic [REG_AW-1:0] s;
        logic              ex_hit, mem_hit;
        logic [NSRC*3-1:0] efwd;
        busy_m = (m_left != 0);
        done_m = (m_left == 1);
        blk    = busy_m && !done_m;
        stall  = blk && id_mc;
        if (blk && id_wreg && id_rd == m_rd) stall = 1'b1;
        efwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            s       = id_src[i*REG_AW +: REG_AW];
            ex_hit  = id_use[i] && ewreg && ern != 0 && ern == s;
            mem_hit = id_use[i] && mwreg && mrn != 0 && mrn == s;
            if (ex_hit && em2reg) stall = 1'b1;
            if (blk && id_use[i] && m_rd != 0 && s == m_rd) stall = 1'b1;
            if (done_m && m_rd != 0 && s == m_rd) efwd[i*3 +: 3] = 3'd4;
            else if (ex_hit)                      efwd[i*3 +: 3] = 3'd1;
            else if (mem_hit)                     efwd[i*3 +: 3] = mm2reg ? 3'd3 : 3'd2;
        end
        exp_wpcir = !stall;
        chk("m_fwd", 32'(fwd), 32'(efwd));
        chk("m_wpcir", 32'(wpcir), 32'(!stall));
        chk("m_bubble", 32'(bubble), 32'(stall));
        chk("m_flush_if", 32'(flush_if), 32'(id_br_taken && !stall));
        chk("m_mc_busy", 32'(mc_busy), 32'(busy_m));
        chk("m_mc_done", 32'(mc_done), 32'(done_m));
        chk("m_mc_rd", 32'(mc_rd), 32'(m_rd));
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    // Model state advance
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_rd   <= '0;
            m_cnt  <= 0;
        end else begin
            if (id_mc && exp_wpcir) begin
                m_left <= MC_LAT;
                m_rd   <= id_wreg ? id_rd : '0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end
            if (!exp_wpcir && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        end
    end

    task automatic idle();
        id_src = '0; id_use = '0; id_wreg = 0; id_rd = '0; id_mc = 0; id_br_taken = 0;
        ewreg = 0; em2reg = 0; ern = '0; mwreg = 0; mm2reg = 0; mrn = '0;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        adv(); adv();
        reset = 1'b0;

        // reset state
        settle();
        chk("rst_wpcir", 32'(wpcir), 32'd1);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_fwd", 32'(fwd), 32'd0);
        chk("rst_mc_busy", 32'(mc_busy), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        adv();

        // forwarding selects
        ewreg = 1; ern = 5; mwreg = 1; mrn = 5; id_src = {5'd0, 5'd5}; id_use = 2'b01;
        settle(); chk("fwd_ex_over_mem", 32'(fwd[2:0]), 32'd1); adv();
        ern = 0; id_src = {5'd0, 5'd0};
        settle(); chk("fwd_r0", 32'(fwd[2:0]), 32'd0); adv();
        idle(); mwreg = 1; mm2reg = 1; mrn = 6; id_src = {5'd6, 5'd0}; id_use = 2'b10;
        settle(); chk("fwd_mem_load", 32'(fwd[5:3]), 32'd3); adv();
        mm2reg = 0;
        settle(); chk("fwd_mem_alu", 32'(fwd[5:3]), 32'd2); adv();

        // load-use
        idle(); ewreg = 1; em2reg = 1; ern = 3; id_src = {5'd0, 5'd3}; id_use = 2'b01;
        settle(); chk("lu_wpcir", 32'(wpcir), 32'd0); chk("lu_bubble", 32'(bubble), 32'd1); adv();
        id_use = 2'b00;
        settle(); chk("lu_nouse_wpcir", 32'(wpcir), 32'd1); chk("lu_cnt", 32'(stall_cnt), 32'd1); adv();

        // mc issue and dependant reader
        idle(); id_mc = 1; id_wreg = 1; id_rd = 7;
        settle(); chk("mc_issue_wpcir", 32'(wpcir), 32'd1); adv();
        idle(); id_src = {5'd0, 5'd7}; id_use = 2'b01;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("mc_raw_wpcir", 32'(wpcir), 32'd0);
            chk("mc_raw_busy", 32'(mc_busy), 32'd1);
            chk("mc_raw_done", 32'(mc_done), 32'd0);
            adv();
        end
        settle();
        chk("mc_done_pulse", 32'(mc_done), 32'd1);
        chk("mc_done_wpcir", 32'(wpcir), 32'd1);
        chk("mc_done_fwd", 32'(fwd[2:0]), 32'd4);
        adv();
        idle();
        settle(); chk("mc_idle_busy", 32'(mc_busy), 32'd0); chk("mc_cnt4", 32'(stall_cnt), 32'd4); adv();

        // back-to-back mc ops
        id_mc = 1; id_wreg = 1; id_rd = 8;
        settle(); adv();
        id_rd = 9;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("b2b_struct_stall", 32'(wpcir), 32'd0); adv();
        end
        settle(); chk("b2b_done", 32'(mc_done), 32'd1); chk("b2b_issue", 32'(wpcir), 32'd1); adv();
        idle();
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk("b2b_busy", 32'(mc_busy), 32'd1);
            chk("b2b_rd", 32'(mc_rd), 32'd9);
            chk("b2b_done2", 32'(mc_done), 32'(k == 4));
            adv();
        end
        settle(); chk("b2b_idle", 32'(mc_busy), 32'd0); chk("b2b_cnt7", 32'(stall_cnt), 32'd7); adv();

        // branch vs stall
        ewreg = 1; em2reg = 1; ern = 2; id_src = {5'd0, 5'd2}; id_use = 2'b01; id_br_taken = 1;
        settle(); chk("br_stall_flush", 32'(flush_if), 32'd0); adv();
        idle(); id_br_taken = 1;
        settle(); chk("br_flush", 32'(flush_if), 32'd1); adv();

        // reset mid-op
        idle(); id_mc = 1; id_wreg = 1; id_rd = 7;
        settle(); adv();
        idle();
        settle(); adv();
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(mc_busy), 32'd0);
        chk("rst_mid_rd", 32'(mc_rd), 32'd0);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle(); chk("rst_no_done", 32'(mc_done), 32'd0); adv();
        end

        // stall counter saturation
        ewreg = 1; em2reg = 1; ern = 4; id_src = {5'd0, 5'd4}; id_use = 2'b01;
        for (int k = 0; k < CNT_MAX + 4; k++) adv();
        idle();
        settle(); chk("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX)); adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
